// File: rtl/par_loader.sv
`default_nettype none
// ============================================================================
//  Module      : par_loader
//  Description : Serial-to-parallel coefficient loader. Receives a framed,
//                MSB-first bit-serial stream (start address, count C, then
//                C+1 data words) and issues one single-cycle write per
//                assembled word on the WrEn/Addr/PAR bus of the NYQ
//                coefficient memory.
//
//  Ports
//    Clk_CI        in   1            system clock, rising edge
//    Rst_RBI       in   1            synchronous active-low reset
//    Ser_Frame_SI  in   1            frame enable, high for whole transfer
//    Ser_Valid_SI  in   1            Ser_Data_DI carries a bit this cycle
//    Ser_Data_DI   in   1            serial bit, MSB first
//    WrEn_SO       out  1            write strobe, one cycle per word
//    Addr_DO       out  ADDR_WIDTH   write address
//    PAR_Out_DO    out  MEM_WIDTH    write data
//    Busy_SO       out  1            frame in progress (header or data)
//    Done_SO       out  1            one-cycle pulse, frame completed
//    Err_SO        out  1            one-cycle pulse, frame aborted
//
//  Revision    : 1.0  initial release
// ============================================================================
module par_loader #(
    parameter int ADDR_WIDTH = 6,
    parameter int MEM_WIDTH  = 24
) (
    input  logic                  Clk_CI,
    input  logic                  Rst_RBI,
    input  logic                  Ser_Frame_SI,
    input  logic                  Ser_Valid_SI,
    input  logic                  Ser_Data_DI,
    output logic                  WrEn_SO,
    output logic [ADDR_WIDTH-1:0] Addr_DO,
    output logic [MEM_WIDTH-1:0]  PAR_Out_DO,
    output logic                  Busy_SO,
    output logic                  Done_SO,
    output logic                  Err_SO
);

    localparam int c_HDR_BITS = 2 * ADDR_WIDTH;
    // One shift register serves both header and data words.
    localparam int c_SR_W     = (MEM_WIDTH > c_HDR_BITS) ? MEM_WIDTH : c_HDR_BITS;
    localparam int c_CNT_W    = $clog2(c_SR_W);

    localparam logic [c_CNT_W-1:0]    c_HDR_LAST  = c_CNT_W'(c_HDR_BITS - 1);
    localparam logic [c_CNT_W-1:0]    c_WORD_LAST = c_CNT_W'(MEM_WIDTH - 1);
    localparam logic [c_CNT_W-1:0]    c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE  = ADDR_WIDTH'(1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_HDR     = 2'd1;
    localparam logic [1:0] S_DATA    = 2'd2;
    localparam logic [1:0] S_WAITLOW = 2'd3;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]            r_state;
    // Holds the previous c_SR_W-1 bits; the incoming bit completes a field.
    logic [c_SR_W-2:0]     r_sr;
    logic [c_CNT_W-1:0]    r_bit_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_words_left;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_addr_out;
    logic [MEM_WIDTH-1:0]  r_par;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    logic [c_SR_W-1:0]     w_sr_shift;
    logic [1:0]            w_state_nx;
    logic [c_SR_W-2:0]     w_sr_nx;
    logic [c_CNT_W-1:0]    w_bit_cnt_nx;
    logic [ADDR_WIDTH-1:0] w_addr_nx;
    logic [ADDR_WIDTH-1:0] w_words_left_nx;
    logic                  w_wr_en_nx;
    logic [ADDR_WIDTH-1:0] w_addr_out_nx;
    logic [MEM_WIDTH-1:0]  w_par_nx;
    logic                  w_busy_nx;
    logic                  w_done_nx;
    logic                  w_err_nx;

    always_comb begin
        w_sr_shift      = {r_sr, Ser_Data_DI};
        w_state_nx      = r_state;
        w_sr_nx         = r_sr;
        w_bit_cnt_nx    = r_bit_cnt;
        w_addr_nx       = r_addr;
        w_words_left_nx = r_words_left;
        w_wr_en_nx      = 1'b0;
        w_addr_out_nx   = r_addr_out;
        w_par_nx        = r_par;
        w_busy_nx       = r_busy;
        w_done_nx       = 1'b0;
        w_err_nx        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (Ser_Frame_SI) begin
                    w_state_nx = S_HDR;
                    w_busy_nx  = 1'b1;
                    // A bit arriving with the frame edge is header bit 0.
                    if (Ser_Valid_SI) begin
                        w_sr_nx      = w_sr_shift[c_SR_W-2:0];
                        w_bit_cnt_nx = c_CNT_ONE;
                    end
                end
            end

            S_HDR, S_DATA: begin
                if (!Ser_Frame_SI) begin
                    // Abort: partial field is dropped, earlier writes stand.
                    w_state_nx   = S_IDLE;
                    w_err_nx     = 1'b1;
                    w_busy_nx    = 1'b0;
                    w_sr_nx      = '0;
                    w_bit_cnt_nx = '0;
                end else if (Ser_Valid_SI) begin
                    w_sr_nx = w_sr_shift[c_SR_W-2:0];
                    if (r_state == S_HDR) begin
                        if (r_bit_cnt == c_HDR_LAST) begin
                            w_addr_nx       = w_sr_shift[c_HDR_BITS-1:ADDR_WIDTH];
                            w_words_left_nx = w_sr_shift[ADDR_WIDTH-1:0];
                            w_bit_cnt_nx    = '0;
                            w_state_nx      = S_DATA;
                        end else begin
                            w_bit_cnt_nx = r_bit_cnt + c_CNT_ONE;
                        end
                    end else begin
                        if (r_bit_cnt == c_WORD_LAST) begin
                            w_bit_cnt_nx  = '0;
                            w_wr_en_nx    = 1'b1;
                            w_addr_out_nx = r_addr;
                            w_par_nx      = w_sr_shift[MEM_WIDTH-1:0];
                            // Address wraps naturally at 2^ADDR_WIDTH.
                            w_addr_nx     = r_addr + c_ADDR_ONE;
                            // Count field is C, so C+1 words end at zero.
                            if (r_words_left == '0) begin
                                w_done_nx  = 1'b1;
                                w_busy_nx  = 1'b0;
                                w_state_nx = S_WAITLOW;
                            end else begin
                                w_words_left_nx = r_words_left - c_ADDR_ONE;
                            end
                        end else begin
                            w_bit_cnt_nx = r_bit_cnt + c_CNT_ONE;
                        end
                    end
                end
            end

            S_WAITLOW: begin
                // Trailing bits are ignored until the frame drops.
                if (!Ser_Frame_SI) begin
                    w_state_nx = S_IDLE;
                end
            end

            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk_CI) begin
        if (!Rst_RBI) begin
            r_state      <= S_IDLE;
            r_sr         <= '0;
            r_bit_cnt    <= '0;
            r_addr       <= '0;
            r_words_left <= '0;
            r_wr_en      <= 1'b0;
            r_addr_out   <= '0;
            r_par        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_sr         <= w_sr_nx;
            r_bit_cnt    <= w_bit_cnt_nx;
            r_addr       <= w_addr_nx;
            r_words_left <= w_words_left_nx;
            r_wr_en      <= w_wr_en_nx;
            r_addr_out   <= w_addr_out_nx;
            r_par        <= w_par_nx;
            r_busy       <= w_busy_nx;
            r_done       <= w_done_nx;
            r_err        <= w_err_nx;
        end
    end

    assign WrEn_SO    = r_wr_en;
    assign Addr_DO    = r_addr_out;
    assign PAR_Out_DO = r_par;
    assign Busy_SO    = r_busy;
    assign Done_SO    = r_done;
    assign Err_SO     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_par_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_par_loader
//  Description : Self-checking bench for par_loader. A bit-queue model
//                decides each cycle's expected outputs from the accepted
//                bits; directed frames additionally pin literal results.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_par_loader;
    localparam int AW = 6;
    localparam int MW = 24;
    localparam int HB = 2 * AW;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          frame = 1'b0;
    logic          valid = 1'b0;
    logic          sdata = 1'b0;
    logic          wr_en;
    logic [AW-1:0] addr;
    logic [MW-1:0] par;
    logic          busy;
    logic          done;
    logic          err;

    par_loader #(.ADDR_WIDTH(AW), .MEM_WIDTH(MW)) dut (
        .Clk_CI       (clk),
        .Rst_RBI      (rst_n),
        .Ser_Frame_SI (frame),
        .Ser_Valid_SI (valid),
        .Ser_Data_DI  (sdata),
        .WrEn_SO      (wr_en),
        .Addr_DO      (addr),
        .PAR_Out_DO   (par),
        .Busy_SO      (busy),
        .Done_SO      (done),
        .Err_SO       (err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // Reference model: collect accepted bits of the current frame and
    // derive writes purely from the bit count and the decoded header.
    // ------------------------------------------------------------------
    bit            m_active = 1'b0;
    bit            m_drain  = 1'b0;
    bit            m_bits[$];
    logic          m_wr   = 1'b0;
    logic          m_busy = 1'b0;
    logic          m_done = 1'b0;
    logic          m_err  = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [MW-1:0] m_par  = '0;

    task automatic model_take(input bit b);
        int n, k, v_start, v_cnt;
        logic [MW-1:0] w;
        m_bits.push_back(b);
        n = m_bits.size();
        if (n > HB && ((n - HB) % MW) == 0) begin
            v_start = 0;
            v_cnt   = 0;
            for (int i = 0; i < AW; i++) begin
                v_start = v_start * 2 + int'(m_bits[i]);
                v_cnt   = v_cnt * 2 + int'(m_bits[AW + i]);
            end
            k = (n - HB) / MW - 1;
            w = '0;
            for (int i = n - MW; i < n; i++) w = {w[MW-2:0], m_bits[i]};
            m_wr   = 1'b1;
            m_addr = AW'((v_start + k) % (1 << AW));
            m_par  = w;
            if (k == v_cnt) begin
                m_done   = 1'b1;
                m_busy   = 1'b0;
                m_active = 1'b0;
                m_drain  = 1'b1;
            end
        end
    endtask

    always @(posedge clk) begin
        m_wr   = 1'b0;
        m_done = 1'b0;
        m_err  = 1'b0;
        if (!rst_n) begin
            m_active = 1'b0;
            m_drain  = 1'b0;
            m_bits.delete();
            m_addr   = '0;
            m_par    = '0;
            m_busy   = 1'b0;
        end else if (m_drain) begin
            if (!frame) m_drain = 1'b0;
        end else if (!m_active) begin
            if (frame) begin
                m_active = 1'b1;
                m_busy   = 1'b1;
                m_bits.delete();
                if (valid) model_take(sdata);
            end
        end else if (!frame) begin
            m_err    = 1'b1;
            m_busy   = 1'b0;
            m_active = 1'b0;
        end else if (valid) begin
            model_take(sdata);
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        n_tests++;
        if (wr_en !== m_wr || addr !== m_addr || par !== m_par ||
            busy !== m_busy || done !== m_done || err !== m_err) begin
            n_fail++;
            $display("FAIL cycle_check cyc=%0d got wr=%b addr=%0d par=%h busy=%b done=%b err=%b, expected wr=%b addr=%0d par=%h busy=%b done=%b err=%b",
                     cyc, wr_en, addr, par, busy, done, err,
                     m_wr, m_addr, m_par, m_busy, m_done, m_err);
        end
    end

    // Write / done / error log for the directed literal checks.
    int log_addr[$];
    int log_data[$];
    int log_cyc[$];
    int done_cyc[$];
    int err_cnt = 0;

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            log_addr.push_back(int'(addr));
            log_data.push_back(int'(par));
            log_cyc.push_back(cyc);
        end
        if (done === 1'b1) done_cyc.push_back(cyc);
        if (err === 1'b1) err_cnt++;
    end

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        log_cyc.delete();
        done_cyc.delete();
        err_cnt = 0;
    endtask

    task automatic check(input string name, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    int            pat = 0;
    int            last_bit_cyc = 0;
    logic [MW-1:0] words_q[$];

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            frame = 1'b0;
            valid = 1'b0;
            sdata = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
    endtask

    // gap_mode: 0 continuous, 1 random gaps, 2 valid pattern 1-0-0-1
    task automatic send_bit(input bit b, input int gap_mode);
        if (gap_mode == 2) begin
            while ((pat % 4) == 1 || (pat % 4) == 2) begin
                valid = 1'b0;
                sdata = 1'($urandom_range(0, 1));
                pat++;
                @(negedge clk);
            end
        end else if (gap_mode == 1) begin
            while ($urandom_range(0, 3) == 0) begin
                valid = 1'b0;
                sdata = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
        end
        valid        = 1'b1;
        sdata        = b;
        last_bit_cyc = cyc;
        pat++;
        @(negedge clk);
    endtask

    // Sends header(a, c) plus words_q. abort_at >= 0 drops the frame in the
    // cycle that would carry that bit; trail keeps the frame high afterwards.
    task automatic send_frame(input int a, input int c, input int gap_mode,
                              input int abort_at, input int trail);
        logic [AW-1:0] av;
        logic [AW-1:0] cv;
        logic [MW-1:0] wv;
        bit            q[$];
        av = AW'(a);
        cv = AW'(c);
        for (int i = AW - 1; i >= 0; i--) q.push_back(av[i]);
        for (int i = AW - 1; i >= 0; i--) q.push_back(cv[i]);
        foreach (words_q[j]) begin
            wv = words_q[j];
            for (int i = MW - 1; i >= 0; i--) q.push_back(wv[i]);
        end
        pat   = 0;
        frame = 1'b1;
        foreach (q[i]) begin
            if (i == abort_at) begin
                frame = 1'b0;
                valid = 1'b1;
                sdata = q[i];
                @(negedge clk);
                idle(3);
                return;
            end
            send_bit(q[i], gap_mode);
        end
        for (int i = 0; i < trail; i++) begin
            valid = 1'($urandom_range(0, 1));
            sdata = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        idle(3);
    endtask

    initial begin
        int c, gm, ab, tr;

        // Reset held with random serial activity.
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            frame = 1'($urandom_range(0, 1));
            valid = 1'($urandom_range(0, 1));
            sdata = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        check("reset_wren", wr_en, 0);
        check("reset_addr", addr, 0);
        check("reset_par",  par, 0);
        check("reset_busy", busy, 0);
        check("reset_done_err", {done, err}, 0);
        rst_n = 1'b1;
        idle(2);

        // Single word.
        clear_log();
        words_q = {24'h123456};
        send_frame(5, 0, 0, -1, 0);
        check("single_nwr",  log_addr.size(), 1);
        check("single_addr", log_addr[0], 5);
        check("single_data", log_data[0], 32'h123456);
        check("single_lat",  log_cyc[0], last_bit_cyc + 1);
        check("single_done", done_cyc.size(), 1);
        check("single_done_cyc", done_cyc[0], log_cyc[0]);
        check("single_busy", busy, 0);

        // Wrap and burst.
        clear_log();
        words_q = {24'h000001, 24'h000002, 24'h000003, 24'h000004};
        send_frame(62, 3, 0, -1, 0);
        check("wrap_nwr", log_addr.size(), 4);
        check("wrap_a0", log_addr[0], 62);
        check("wrap_a1", log_addr[1], 63);
        check("wrap_a2", log_addr[2], 0);
        check("wrap_a3", log_addr[3], 1);
        check("wrap_d3", log_data[3], 4);
        check("wrap_space1", log_cyc[1] - log_cyc[0], 24);
        check("wrap_space3", log_cyc[3] - log_cyc[2], 24);
        check("wrap_done_cyc", done_cyc[0], log_cyc[3]);

        // Valid gaps 1-0-0-1.
        clear_log();
        words_q = {24'h123456};
        send_frame(5, 0, 2, -1, 0);
        check("gap_addr", log_addr[0], 5);
        check("gap_data", log_data[0], 32'h123456);
        check("gap_lat",  log_cyc[0], last_bit_cyc + 1);

        // Abort after first word plus 7 bits.
        clear_log();
        words_q = {24'hABCDEF, 24'h111111, 24'h222222};
        send_frame(10, 2, 0, HB + MW + 7, 0);
        check("abort_nwr",  log_addr.size(), 1);
        check("abort_addr", log_addr[0], 10);
        check("abort_data", log_data[0], 32'hABCDEF);
        check("abort_err",  err_cnt, 1);
        check("abort_done", done_cyc.size(), 0);
        clear_log();
        words_q = {24'h5A5A5A};
        send_frame(20, 0, 0, -1, 0);
        check("after_abort_addr", log_addr[0], 20);
        check("after_abort_data", log_data[0], 32'h5A5A5A);

        // Frame drops exactly on the last data bit.
        clear_log();
        words_q = {24'h0F0F0F, 24'hF0F0F0};
        send_frame(7, 1, 0, HB + 2 * MW - 1, 0);
        check("lastbit_nwr",  log_addr.size(), 1);
        check("lastbit_err",  err_cnt, 1);
        check("lastbit_done", done_cyc.size(), 0);

        // Trailing bits after done are ignored.
        clear_log();
        words_q = {24'h777777, 24'h888888};
        send_frame(40, 1, 1, -1, 30);
        check("trail_nwr",  log_addr.size(), 2);
        check("trail_done", done_cyc.size(), 1);
        check("trail_err",  err_cnt, 0);
        clear_log();
        words_q = {24'hC0FFEE};
        send_frame(3, 0, 0, -1, 0);
        check("trail_next_addr", log_addr[0], 3);
        check("trail_next_data", log_data[0], 32'hC0FFEE);

        // Reset in the middle of a frame.
        frame = 1'b1;
        for (int i = 0; i < 20; i++) send_bit(1'($urandom_range(0, 1)), 0);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Randomized frames, checked by the model every cycle.
        for (int f = 0; f < 40; f++) begin
            c = (f == 7) ? 63 : int'($urandom_range(0, 3));
            words_q.delete();
            for (int w = 0; w <= c; w++) words_q.push_back(MW'($urandom));
            gm = int'($urandom_range(0, 2));
            ab = ($urandom_range(0, 4) == 0) ?
                 int'($urandom_range(1, HB + (c + 1) * MW - 1)) : -1;
            tr = int'($urandom_range(0, 5));
            send_frame(int'($urandom_range(0, 63)), c, gm, ab, tr);
        end

        idle(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
